multivoice_fetch_sequencer: RTL
===============================

// Module: multivoice_fetch_sequencer
// PURPOSE
//  Per-sample-period RAM fetch sequencer for the synth sampler. On each rising edge of sample_clk it
//  visits voices 0..N_VOICES-1 in order. For each enabled voice it waits for that voice's address
//  generator (done), loads the shared MAR, holds OE through the RAM access, and strobes that voice's MDR.
//  It sits between the per-voice address/note counters and the shared sample RAM/MDR bank.
// PARAMETERS
//  N_VOICES   4   voice count, 1..16
//  RAM_WAIT   2   cycles OE is held low between MAR load and MDR store, >=1
//  SEL_W      max(1,$clog2(N_VOICES))   width of select (derived, do not override)
// PORTS
//  Clk         in   1          system clock; all logic on posedge
//  Reset       in   1          synchronous, active-high reset
//  sample_clk  in   1          sample-rate strobe, level, synchronous to Clk
//  init        in   1          start sequencing (honoured only in IDLE)
//  voice_en    in   N_VOICES   per-voice enable, sampled in SCAN
//  done        in   N_VOICES   per-voice address-ready (level)
//  MAR_LD      out  1          load shared MAR from address mux
//  OE          out  1          RAM output enable, active-low
//  MDR_LD      out  N_VOICES   one-hot MDR load strobe
//  select      out  SEL_W      address-mux / voice index
//  frame_done  out  1          1-cycle pulse: all voices of this period serviced
//  overrun     out  1          1-cycle pulse: sample_clk rose while a round was active
// BEHAVIOUR
//  Reset: state=IDLE, idx=0, sclk_q=0. Outputs: MAR_LD=0, MDR_LD=0, OE=1, select=0, frame_done=0,
//   overrun=0. Reset mid-round aborts the round immediately. No partial strobes occur after the reset cycle.
//  Edge detect: sclk_q<=sample_clk every cycle; rise = sample_clk & ~sclk_q.
//  States and transitions:
//   IDLE       : init -> WAIT_EDGE.
//   WAIT_EDGE  : rise -> SCAN with idx=0.
//   SCAN       : ~voice_en[idx] -> advance. done[idx] -> LOAD_MAR. Otherwise -> WAIT_DONE.
//   WAIT_DONE  : done[idx] -> LOAD_MAR. No timeout.
//   LOAD_MAR   : MAR_LD=1 for 1 cycle -> RAM_WAIT with wait counter=0.
//   RAM_WAIT   : OE=0. Counter increments. After RAM_WAIT cycles -> STORE.
//   STORE      : OE=0, MDR_LD[idx]=1 for 1 cycle -> advance.
//   advance    : idx==N_VOICES-1 -> FRAME_END; else idx++ -> SCAN.
//   FRAME_END  : frame_done=1 for 1 cycle -> WAIT_EDGE.
//  select=idx in every state except IDLE and WAIT_EDGE, where select=0.
//  Outputs are Moore and decoded from state only. OE=1 in all states except RAM_WAIT and STORE.
//  MDR_LD is one-hot during STORE and zero otherwise. MAR_LD and MDR_LD are never high together.
//  Per enabled voice with done already high: RAM_WAIT+3 cycles (SCAN, LOAD_MAR, RAM_WAIT x W, STORE).
//   A disabled voice costs 1 SCAN cycle.
//  overrun: a rise seen in any state other than IDLE/WAIT_EDGE pulses overrun for 1 cycle.
//   That edge is dropped, not queued, and the current round continues unchanged.
//   A rise in the same cycle as FRAME_END counts as overrun.
//  voice_en/done changes mid-access do not abort that access. en is sampled only in SCAN;
//   done is sampled only in SCAN/WAIT_DONE.
//  init outside IDLE is ignored. Only Reset returns the block to IDLE.
//  All voices disabled: N_VOICES SCAN cycles, then frame_done.
// TESTING (N_VOICES=4, RAM_WAIT=2; rise detected at cycle t)
//  1 Reset mid-RAM_WAIT -> next cycle OE=1, MDR_LD=0, select=0; init required to restart.
//  2 All en=1, done=4'hF -> MAR_LD at t+2,t+7,t+12,t+17; MDR_LD=0001@t+5, 0010@t+10,
//    0100@t+15, 1000@t+20; frame_done@t+21; OE=0 exactly t+3..t+5 and similar per voice.
//  3 en=4'b0101, done=4'hF -> MDR_LD 0001@t+5, 0100@t+11; frame_done@t+13; no strobe for 1 or 3.
//  4 en=4'hF, done[1] held low until t+20 -> select=1 for t+6..t+20; MAR_LD@t+21; MDR_LD=0010@t+24.
//  5 second sample_clk rise during voice 2 fetch -> overrun pulse 1 cycle; round completes;
//    no new round until the next rise after frame_done.
//  6 en=0 -> frame_done@t+5, no MAR_LD/MDR_LD, OE stays 1; init pulsed mid-round -> no effect.

Source files
------------

// File: rtl/multivoice_fetch_sequencer.sv
// Per-sample-period fetch sequencer: walks the voices in order on each sample_clk rise,
// loading the shared MAR, holding OE through the RAM access and strobing the voice's MDR.
module multivoice_fetch_sequencer #(
  parameter int N_VOICES = 4,
  parameter int RAM_WAIT = 2,
  parameter int SEL_W    = (N_VOICES > 1) ? $clog2(N_VOICES) : 1
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                sample_clk,
  input  logic                init,
  input  logic [N_VOICES-1:0] voice_en,
  input  logic [N_VOICES-1:0] done,
  output logic                MAR_LD,
  output logic                OE,
  output logic [N_VOICES-1:0] MDR_LD,
  output logic [SEL_W-1:0]    select,
  output logic                frame_done,
  output logic                overrun
);
  localparam int CNT_W = (RAM_WAIT > 1) ? $clog2(RAM_WAIT) : 1;

  typedef enum logic [2:0] {
    IDLE, WAIT_EDGE, SCAN, WAIT_DONE, LOAD_MAR, RAM_WT, STORE, FRAME_END
  } state_t;

  state_t            state, state_d;
  logic [SEL_W-1:0]  idx, idx_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic              sclk_q, rise, active;

  assign rise   = sample_clk & ~sclk_q;
  assign active = (state != IDLE) && (state != WAIT_EDGE);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= IDLE;
      idx     <= '0;
      cnt     <= '0;
      sclk_q  <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state   <= state_d;
      idx     <= idx_d;
      cnt     <= cnt_d;
      sclk_q  <= sample_clk;
      // edges during a round are dropped; only flagged
      overrun <= rise & active;
    end
  end

  always_comb begin
    state_d = state;
    idx_d   = idx;
    cnt_d   = cnt;
    case (state)
      IDLE:      if (init) state_d = WAIT_EDGE;
      WAIT_EDGE: if (rise) begin
                   state_d = SCAN;
                   idx_d   = '0;
                 end
      SCAN:      if (!voice_en[idx]) begin
                   if (idx == SEL_W'(N_VOICES-1)) state_d = FRAME_END;
                   else idx_d = idx + 1'b1;
                 end else if (done[idx]) state_d = LOAD_MAR;
                 else state_d = WAIT_DONE;
      WAIT_DONE: if (done[idx]) state_d = LOAD_MAR;
      LOAD_MAR:  begin
                   state_d = RAM_WT;
                   cnt_d   = '0;
                 end
      RAM_WT:    if (cnt == CNT_W'(RAM_WAIT-1)) state_d = STORE;
                 else cnt_d = cnt + 1'b1;
      STORE:     if (idx == SEL_W'(N_VOICES-1)) state_d = FRAME_END;
                 else begin
                   state_d = SCAN;
                   idx_d   = idx + 1'b1;
                 end
      FRAME_END: state_d = WAIT_EDGE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    MAR_LD     = (state == LOAD_MAR);
    OE         = !((state == RAM_WT) || (state == STORE));
    frame_done = (state == FRAME_END);
    select     = ((state == IDLE) || (state == WAIT_EDGE)) ? '0 : idx;
    MDR_LD     = '0;
    for (int v = 0; v < N_VOICES; v++)
      MDR_LD[v] = (state == STORE) && (idx == SEL_W'(v));
  end
endmodule
